run_ctrl: RTL and testbench

- Run controller and data-memory arbiter for the 9-bit accumulator core.
- Owns the core's `start` (PC/regfile reset) line and shares the single `dat_mem` port between a host loader and the core.
- Host preloads memory, pulses go, the core runs until `done` or a cycle limit, then the host reads back results.
- Sits between top_level's core, dat_mem and the host/testbench.

---
 rtl/run_ctrl_pkg.sv | 22 ++
 rtl/run_ctrl_sat_counter.sv | 30 +++
 rtl/run_ctrl.sv | 123 ++++++++++++
 tb/tb_run_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared widths and run-controller state encoding for the accumulator core's
// run controller and anything in top_level that talks to it.
package run_ctrl_pkg;

  localparam int RC_AW = 8;
  localparam int RC_DW = 8;
  localparam int RC_CW = 16;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  // The host owns dat_mem in every state except while a program is launching or running.
  function automatic logic host_owns(input state_t s);
    return (s != ST_START) && (s != ST_RUN);
  endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// CW-bit up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter
  import run_ctrl_pkg::*;
#(
  parameter int CW = RC_CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !(&count_reg)) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core start/run/stop and arbitrates the single
// dat_mem port between the host loader and the core.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int            AW        = RC_AW,
  parameter int            DW        = RC_DW,
  parameter int            CW        = RC_CW,
  parameter logic [CW-1:0] MAX_CYC   = CW'(4000),
  parameter int            START_LEN = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          host_go,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdat,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdat,
  output logic          core_start,
  input  logic          core_done,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdat,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat,
  output logic          busy,
  output logic          run_done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  localparam int            SW       = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SW-1:0] START_LD = SW'(START_LEN - 1);
  localparam logic [SW-1:0] SW_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_CYC = MAX_CYC - {{(CW-1){1'b0}}, 1'b1};

  state_t        state_reg, state_next;
  logic [SW-1:0] start_cnt_reg, start_cnt_next;
  logic          timeout_reg, timeout_next;
  logic          go_accept;
  logic          host_side;

  assign go_accept = (state_reg == ST_IDLE) && host_go;

  always_comb begin
    state_next     = state_reg;
    start_cnt_next = start_cnt_reg;
    timeout_next   = timeout_reg;
    case (state_reg)
      ST_IDLE: begin
        if (host_go) begin
          state_next     = ST_START;
          start_cnt_next = START_LD;
          timeout_next   = 1'b0;
        end
      end
      ST_START: begin
        if (start_cnt_reg == '0) begin
          state_next = ST_RUN;
        end else begin
          start_cnt_next = start_cnt_reg - SW_ONE;
        end
      end
      ST_RUN: begin
        // A done flag on the limit cycle still counts as a normal completion.
        if (core_done) begin
          state_next = ST_DONE;
        end else if (cycle_cnt == LAST_CYC) begin
          state_next   = ST_TIMEOUT;
          timeout_next = 1'b1;
        end
      end
      ST_DONE, ST_TIMEOUT: state_next = ST_IDLE;
      default:             state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      start_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      start_cnt_reg <= start_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  // The done cycle itself is not counted, so cycle_cnt reports completed work cycles.
  sat_counter #(
    .CW(CW)
  ) u_cycle_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (go_accept),
    .en     ((state_reg == ST_RUN) && !core_done),
    .count  (cycle_cnt)
  );

  assign core_start = (state_reg != ST_RUN);
  assign busy       = (state_reg == ST_START) || (state_reg == ST_RUN);
  assign run_done   = (state_reg == ST_DONE);
  assign timeout    = timeout_reg;

  assign host_side = host_owns(state_reg);
  assign host_gnt  = host_side & host_req;
  assign mem_we    = host_side ? (host_req & host_we) : (core_we & (state_reg == ST_RUN));
  assign mem_addr  = host_side ? host_addr : core_addr;
  assign mem_wdat  = host_side ? host_wdat : core_wdat;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_rdat
      assign host_rdat[gi] = mem_rdat[gi] & host_gnt;
    end
  endgenerate

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized bench for run_ctrl with a behavioural dat_mem and a reference
// memory/run model derived from the run rules (START_LEN=2, MAX_CYC=20).
module tb_run_ctrl;

  localparam int MAXC = 20;
  localparam int SLEN = 2;

  logic        clk;
  logic        reset_n;
  logic        host_go, host_req, host_we;
  logic [7:0]  host_addr, host_wdat;
  logic        host_gnt;
  logic [7:0]  host_rdat;
  logic        core_start, core_done, core_we;
  logic [7:0]  core_addr, core_wdat;
  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdat, mem_rdat;
  logic        busy, run_done, timeout;
  logic [15:0] cycle_cnt;

  logic [7:0]  tb_mem  [0:255];
  logic [7:0]  ref_mem [0:255];

  int checks;
  int failures;
  int done_pulses;

  run_ctrl #(
    .AW(8), .DW(8), .CW(16), .MAX_CYC(16'd20), .START_LEN(SLEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .host_go(host_go), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat),
    .host_gnt(host_gnt), .host_rdat(host_rdat), .core_start(core_start),
    .core_done(core_done), .core_we(core_we), .core_addr(core_addr),
    .core_wdat(core_wdat), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat), .busy(busy),
    .run_done(run_done), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdat;
  assign mem_rdat = tb_mem[mem_addr];

  always @(posedge clk) if (run_done === 1'b1) done_pulses++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs;
    host_go = 0; host_req = 0; host_we = 0; host_addr = 0; host_wdat = 0;
    core_done = 0; core_we = 0; core_addr = 0; core_wdat = 0;
  endtask

  task automatic test_reset;
    quiet_inputs();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({core_start, busy, run_done, timeout} !== 4'b1000 || cycle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got start/busy/done/to=%b cnt=%0d exp=1000 cnt=0",
               {core_start, busy, run_done, timeout}, cycle_cnt);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({core_start, busy, run_done, timeout} !== 4'b1000 || cycle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL idle_after_reset got start/busy/done/to=%b cnt=%0d exp=1000 cnt=0",
               {core_start, busy, run_done, timeout}, cycle_cnt);
    end
    $display("reset: released, core held in start");
  endtask

  task automatic test_host_access;
    host_req = 1; host_we = 1; host_addr = 8'h10; host_wdat = 8'h5A;
    #1;
    checks++;
    if ({host_gnt, mem_we} !== 2'b11 || mem_addr !== 8'h10 || mem_wdat !== 8'h5A) begin
      failures++;
      $display("FAIL host_write gnt/we=%b addr=%h wdat=%h exp gnt/we=11 addr=10 wdat=5a",
               {host_gnt, mem_we}, mem_addr, mem_wdat);
    end
    tick();
    ref_mem[8'h10] = 8'h5A;
    host_we = 0;
    #1;
    checks++;
    if (host_rdat !== 8'h5A) begin
      failures++;
      $display("FAIL host_readback got=%h exp=5a", host_rdat);
    end
    $display("host: wrote 5a to 10, read back %h", host_rdat);
    tick();
    for (int n = 0; n < 16; n++) begin
      host_req = 1'($urandom); host_we = 1'($urandom);
      host_addr = 8'($urandom); host_wdat = 8'($urandom);
      #1;
      checks++;
      if (host_gnt !== host_req || mem_we !== (host_req & host_we) ||
          host_rdat !== (host_req ? ref_mem[host_addr] : 8'h00)) begin
        failures++;
        $display("FAIL host_random req=%b we=%b addr=%h gnt=%b mem_we=%b rdat=%h exp_rdat=%h",
                 host_req, host_we, host_addr, host_gnt, mem_we, host_rdat,
                 host_req ? ref_mem[host_addr] : 8'h00);
      end
      $display("host: req=%b we=%b addr=%h wdat=%h rdat=%h", host_req, host_we, host_addr,
               host_wdat, host_rdat);
      tick();
      if (host_req && host_we) ref_mem[host_addr] = host_wdat;
    end
    quiet_inputs();
  endtask

  // Drives one complete program run. done_at is the RUN cycle (1-based) with
  // core_done high; 0 or anything beyond MAXC means the core never finishes.
  task automatic run_program(input int done_at, input bit done_in_start, input bit go_with_req);
    int  pulses0;
    bit  ended_done;
    bit  finished;
    ended_done = (done_at >= 1) && (done_at <= MAXC);
    pulses0    = done_pulses;
    host_go = 1;
    if (go_with_req) begin
      host_req = 1; host_we = 1; host_addr = 8'($urandom); host_wdat = 8'($urandom);
    end
    #1;
    checks++;
    if (host_gnt !== go_with_req || mem_we !== go_with_req) begin
      failures++;
      $display("FAIL go_cycle_host gnt=%b we=%b exp=%b", host_gnt, mem_we, go_with_req);
    end
    tick();
    if (go_with_req) ref_mem[host_addr] = host_wdat;

    for (int i = 1; i <= SLEN; i++) begin
      host_go = 1'($urandom); core_done = done_in_start;
      core_we = 1'($urandom); core_addr = 8'($urandom); core_wdat = 8'($urandom);
      host_req = 1'($urandom); host_we = 1'($urandom); host_addr = 8'($urandom);
      #1;
      checks++;
      if ({core_start, busy, host_gnt, mem_we, run_done, timeout} !== 6'b110000 ||
          mem_addr !== core_addr || host_rdat !== 8'h00 || cycle_cnt !== 16'd0) begin
        failures++;
        $display("FAIL start_cycle%0d start/busy/gnt/we/done/to=%b addr=%h cnt=%0d exp=110000 addr=%h cnt=0",
                 i, {core_start, busy, host_gnt, mem_we, run_done, timeout}, mem_addr,
                 cycle_cnt, core_addr);
      end
      tick();
    end

    finished = 0;
    for (int i = 1; !finished; i++) begin
      host_go = 1'($urandom); core_done = (i == done_at);
      core_we = 1'($urandom); core_addr = 8'($urandom); core_wdat = 8'($urandom);
      if (core_addr == 8'h20) core_addr = 8'h21;
      if (i == 3) begin
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdat = 8'hEE;
      end else begin
        host_req = 1'($urandom); host_we = 1'($urandom); host_addr = 8'($urandom);
      end
      #1;
      checks++;
      if ({core_start, busy, host_gnt, run_done} !== 4'b0100 || mem_we !== core_we ||
          mem_addr !== core_addr || mem_wdat !== core_wdat || cycle_cnt !== 16'(i - 1)) begin
        failures++;
        $display("FAIL run_cycle%0d start/busy/gnt/done=%b we=%b addr=%h cnt=%0d exp=0100 we=%b addr=%h cnt=%0d",
                 i, {core_start, busy, host_gnt, run_done}, mem_we, mem_addr, cycle_cnt,
                 core_we, core_addr, i - 1);
      end
      tick();
      if (core_we) ref_mem[core_addr] = core_wdat;
      finished = (i == done_at) || (i == MAXC);
    end

    core_done = 0; core_we = 0; host_go = 0;
    host_req = 1'($urandom); host_we = 1'($urandom);
    host_addr = 8'($urandom); host_wdat = 8'($urandom);
    #1;
    checks++;
    if ({run_done, timeout} !== (ended_done ? 2'b10 : 2'b01) ||
        {core_start, busy} !== 2'b10 || host_gnt !== host_req ||
        cycle_cnt !== (ended_done ? 16'(done_at - 1) : 16'(MAXC))) begin
      failures++;
      $display("FAIL run_end done/to=%b start/busy=%b gnt=%b cnt=%0d exp done/to=%b start/busy=10 gnt=%b cnt=%0d",
               {run_done, timeout}, {core_start, busy}, host_gnt, cycle_cnt,
               ended_done ? 2'b10 : 2'b01, host_req, ended_done ? done_at - 1 : MAXC);
    end
    tick();
    if (host_req && host_we) ref_mem[host_addr] = host_wdat;
    quiet_inputs();
    #1;
    checks++;
    if ({core_start, busy, run_done} !== 3'b100 || timeout !== !ended_done ||
        (done_pulses - pulses0) !== int'(ended_done) ||
        cycle_cnt !== (ended_done ? 16'(done_at - 1) : 16'(MAXC))) begin
      failures++;
      $display("FAIL run_idle start/busy/done=%b to=%b pulses=%0d cnt=%0d exp=100 to=%b pulses=%0d",
               {core_start, busy, run_done}, timeout, done_pulses - pulses0, cycle_cnt,
               !ended_done, int'(ended_done));
    end
    $display("run: done_at=%0d start_done=%b outcome=%s cycle_cnt=%0d", done_at, done_in_start,
             ended_done ? "done" : "timeout", cycle_cnt);
    tick();
  endtask

  task automatic test_done_run;
    run_program(12, 0, 1);
  endtask

  task automatic test_timeout;
    run_program(0, 0, 0);
  endtask

  task automatic test_done_in_start;
    run_program(5, 1, 0);
  endtask

  task automatic test_done_at_limit;
    run_program(MAXC, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++)
      run_program(int'($urandom_range(0, 24)), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_mid_run;
    int pulses0;
    pulses0 = done_pulses;
    host_go = 1;
    tick();
    host_go = 0;
    repeat (SLEN) tick();
    repeat (4) tick();
    host_req = 1; host_we = 0; host_addr = 8'h10;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({core_start, busy, run_done, host_gnt} !== 4'b1001 || cycle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_run start/busy/done/gnt=%b cnt=%0d exp=1001 cnt=0",
               {core_start, busy, run_done, host_gnt}, cycle_cnt);
    end
    tick();
    reset_n = 1'b1;
    quiet_inputs();
    tick();
    checks++;
    if (busy !== 1'b0 || core_start !== 1'b1 || done_pulses !== pulses0) begin
      failures++;
      $display("FAIL after_mid_reset busy=%b start=%b pulses=%0d exp busy=0 start=1 pulses=%0d",
               busy, core_start, done_pulses, pulses0);
    end
    $display("reset: asserted on run cycle 5, cycle_cnt=%0d", cycle_cnt);
  endtask

  task automatic test_readback;
    for (int a = 0; a < 256; a++) begin
      host_req = 1; host_we = 0; host_addr = 8'(a);
      #1;
      checks++;
      if (host_rdat !== ref_mem[a]) begin
        failures++;
        $display("FAIL readback addr=%h got=%h exp=%h", host_addr, host_rdat, ref_mem[a]);
      end
      tick();
    end
    $display("readback: swept 256 addresses, addr 20 holds %h", ref_mem[8'h20]);
    quiet_inputs();
  endtask

  initial begin
    checks = 0; failures = 0; done_pulses = 0;
    reset_n = 1'b1;
    for (int a = 0; a < 256; a++) begin
      tb_mem[a]  = 8'h00;
      ref_mem[a] = 8'h00;
    end
    quiet_inputs();
    test_reset();
    test_host_access();
    test_done_run();
    test_timeout();
    test_done_in_start();
    test_done_at_limit();
    test_back_to_back();
    test_reset_mid_run();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
